// File: rtl/top_8227_pkg.sv
`default_nettype none
// ============================================================================
// top_8227_pkg : opcodes, timing states, P bit indices and decode helpers
// Rev 1.0
// ============================================================================
package top_8227_pkg;

    localparam logic [7:0] c_OP_BPL     = 8'h10;
    localparam logic [7:0] c_OP_BMI     = 8'h30;
    localparam logic [7:0] c_OP_BVC     = 8'h50;
    localparam logic [7:0] c_OP_BVS     = 8'h70;
    localparam logic [7:0] c_OP_BCC     = 8'h90;
    localparam logic [7:0] c_OP_BCS     = 8'hB0;
    localparam logic [7:0] c_OP_BNE     = 8'hD0;
    localparam logic [7:0] c_OP_BEQ     = 8'hF0;
    localparam logic [7:0] c_OP_CLC     = 8'h18;
    localparam logic [7:0] c_OP_SEC     = 8'h38;
    localparam logic [7:0] c_OP_CLI     = 8'h58;
    localparam logic [7:0] c_OP_SEI     = 8'h78;
    localparam logic [7:0] c_OP_CLV     = 8'hB8;
    localparam logic [7:0] c_OP_CLD     = 8'hD8;
    localparam logic [7:0] c_OP_SED     = 8'hF8;
    localparam logic [7:0] c_OP_INX     = 8'hE8;
    localparam logic [7:0] c_OP_DEX     = 8'hCA;
    localparam logic [7:0] c_OP_INY     = 8'hC8;
    localparam logic [7:0] c_OP_DEY     = 8'h88;
    localparam logic [7:0] c_OP_NOP     = 8'hEA;
    localparam logic [7:0] c_OP_INC_ABS = 8'hEE;
    localparam logic [7:0] c_OP_DEC_ABS = 8'hCE;
    localparam logic [7:0] c_OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] c_OP_JMP_IND = 8'h6C;

    localparam logic [3:0] c_ST_RESET = 4'd0;
    localparam logic [3:0] c_ST_T0    = 4'd1;
    localparam logic [3:0] c_ST_T1    = 4'd2;
    localparam logic [3:0] c_ST_T2    = 4'd3;
    localparam logic [3:0] c_ST_T3    = 4'd4;
    localparam logic [3:0] c_ST_T4    = 4'd5;
    localparam logic [3:0] c_ST_T5    = 4'd6;
    localparam logic [3:0] c_ST_T6    = 4'd7;
    localparam logic [3:0] c_ST_INT   = 4'd8;

    // T1..T6 are shared by instructions and the reset/interrupt sequences
    localparam logic [1:0] c_MODE_INST = 2'd0;
    localparam logic [1:0] c_MODE_RST  = 2'd1;
    localparam logic [1:0] c_MODE_INT  = 2'd2;

    localparam int c_P_C = 0;
    localparam int c_P_Z = 1;
    localparam int c_P_I = 2;
    localparam int c_P_D = 3;
    localparam int c_P_B = 4;
    localparam int c_P_V = 6;
    localparam int c_P_N = 7;

    localparam logic [7:0]  c_P_RESET      = 8'h34;
    localparam logic [15:0] c_RESET_VECTOR = 16'hFFFC;
    localparam logic [15:0] c_NMI_VECTOR   = 16'hFFFA;
    localparam logic [15:0] c_IRQ_VECTOR   = 16'hFFFE;
    localparam logic [7:0]  c_STACK_PAGE   = 8'h01;

    typedef enum logic [2:0] {
        OPC_NOP,
        OPC_BRANCH,
        OPC_FLAG,
        OPC_REG,
        OPC_INCDEC,
        OPC_JMP_ABS,
        OPC_JMP_IND
    } op_class_e;

    function automatic op_class_e decode_class(input logic [7:0] op);
        case (op)
            c_OP_BPL, c_OP_BMI, c_OP_BVC, c_OP_BVS,
            c_OP_BCC, c_OP_BCS, c_OP_BNE, c_OP_BEQ:     decode_class = OPC_BRANCH;
            c_OP_CLC, c_OP_SEC, c_OP_CLI, c_OP_SEI,
            c_OP_CLV, c_OP_CLD, c_OP_SED:               decode_class = OPC_FLAG;
            c_OP_INX, c_OP_DEX, c_OP_INY, c_OP_DEY:     decode_class = OPC_REG;
            c_OP_INC_ABS, c_OP_DEC_ABS:                 decode_class = OPC_INCDEC;
            c_OP_JMP_ABS:                               decode_class = OPC_JMP_ABS;
            c_OP_JMP_IND:                               decode_class = OPC_JMP_IND;
            c_OP_NOP:                                   decode_class = OPC_NOP;
            default:                                    decode_class = OPC_NOP;
        endcase
    endfunction

    // Opcode bits 7:6 pick the flag (N,V,C,Z), bit 5 the value that takes the branch
    function automatic logic branch_taken(input logic [7:0] op, input logic [7:0] p);
        logic flag;
        case (op[7:6])
            2'b00:   flag = p[c_P_N];
            2'b01:   flag = p[c_P_V];
            2'b10:   flag = p[c_P_C];
            default: flag = p[c_P_Z];
        endcase
        branch_taken = (flag == op[5]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/top_8227_incdec.sv
`default_nettype none
// ============================================================================
// top_8227_incdec : 8-bit increment/decrement with N and Z results
// Rev 1.0
// ============================================================================
module top_8227_incdec
    import top_8227_pkg::*;
(
    input  logic [7:0] i_operand,
    input  logic       i_decrement,
    output logic [7:0] o_result,
    output logic       o_negative,
    output logic       o_zero
);

    always_comb begin
        o_result   = i_decrement ? (i_operand - 8'd1) : (i_operand + 8'd1);
        o_negative = o_result[c_P_N];
        o_zero     = (o_result == 8'd0);
    end

endmodule
`default_nettype wire

// File: rtl/top_8227.sv
`default_nettype none
// ============================================================================
// top_8227 : reduced 6502-style CPU core, one bus cycle per clock
// Rev 1.0
// ============================================================================
module top_8227
    import top_8227_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = c_RESET_VECTOR,
    parameter logic [15:0] NMI_VECTOR   = c_NMI_VECTOR,
    parameter logic [15:0] IRQ_VECTOR   = c_IRQ_VECTOR
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       nonMaskableInterrupt,
    input  logic       interruptRequest,
    input  logic [7:0] dataBusInput,
    output logic [7:0] dataBusOutput,
    output logic [7:0] addressBusHigh,
    output logic [7:0] addressBusLow,
    output logic       dataBusEnable,
    input  logic       ready,
    output logic       sync,
    output logic       readNotWrite,
    input  logic       setOverflow
);

    logic [3:0]  state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  a_q, a_d, x_q, x_d, y_q, y_d, s_q, s_d, p_q, p_d;
    logic [7:0]  ir_q, ir_d, data_q, data_d;
    logic [15:0] pc_q, pc_d, ea_q, ea_d;
    logic        int_nmi_q, int_nmi_d, nmi_prev_q, nmi_prev_d;
    logic        nmi_pend_q, nmi_pend_d, so_prev_q, so_prev_d;

    logic [15:0] w_addr, w_vec, w_branch_target;
    logic [7:0]  w_dout, w_id_in, w_id_res;
    logic        w_rnw, w_sync, w_stall, w_end, w_take_int, w_nmi_clear;
    logic        w_id_dec, w_id_n, w_id_z;
    op_class_e   w_cls;

    assign w_cls           = decode_class(ir_q);
    assign w_vec           = int_nmi_q ? NMI_VECTOR : IRQ_VECTOR;
    assign w_branch_target = pc_q + {{8{data_q[7]}}, data_q};
    assign w_take_int      = nmi_pend_q | (interruptRequest & ~p_q[c_P_I]);
    assign w_stall         = ~ready & w_rnw;

    always_comb begin
        w_id_in  = data_q;
        w_id_dec = (ir_q == c_OP_DEC_ABS);
        case (ir_q)
            c_OP_INX: begin w_id_in = x_q; w_id_dec = 1'b0; end
            c_OP_DEX: begin w_id_in = x_q; w_id_dec = 1'b1; end
            c_OP_INY: begin w_id_in = y_q; w_id_dec = 1'b0; end
            c_OP_DEY: begin w_id_in = y_q; w_id_dec = 1'b1; end
            default:  ;
        endcase
    end

    top_8227_incdec u_incdec (
        .i_operand   (w_id_in),
        .i_decrement (w_id_dec),
        .o_result    (w_id_res),
        .o_negative  (w_id_n),
        .o_zero      (w_id_z)
    );

    always_comb begin
        w_addr = pc_q;
        w_rnw  = 1'b1;
        w_dout = 8'h00;
        w_sync = 1'b0;
        if (mode_q != c_MODE_INST) begin
            case (state_q)
                c_ST_T2, c_ST_T3, c_ST_T4: begin
                    w_addr = {c_STACK_PAGE, s_q};
                    if (mode_q == c_MODE_INT) begin
                        w_rnw = 1'b0;
                        if (state_q == c_ST_T2)      w_dout = pc_q[15:8];
                        else if (state_q == c_ST_T3) w_dout = pc_q[7:0];
                        else begin
                            w_dout         = p_q;
                            w_dout[c_P_B]  = 1'b0;
                            w_dout[5]      = 1'b1;
                        end
                    end
                end
                c_ST_T5: w_addr = (mode_q == c_MODE_RST) ? RESET_VECTOR : w_vec;
                c_ST_T6: w_addr = ((mode_q == c_MODE_RST) ? RESET_VECTOR : w_vec) + 16'd1;
                default: ;
            endcase
        end else begin
            case (state_q)
                c_ST_T0: w_sync = 1'b1;
                c_ST_T3: if (w_cls == OPC_INCDEC || w_cls == OPC_JMP_IND) w_addr = ea_q;
                c_ST_T4: begin
                    if (w_cls == OPC_INCDEC) begin
                        w_addr = ea_q;
                        w_rnw  = 1'b0;
                        w_dout = data_q;
                    end else if (w_cls == OPC_JMP_IND) begin
                        // pointer high byte never carries into the next page
                        w_addr = {ea_q[15:8], ea_q[7:0] + 8'd1};
                    end
                end
                c_ST_T5: if (w_cls == OPC_INCDEC) begin
                    w_addr = ea_q;
                    w_rnw  = 1'b0;
                    w_dout = w_id_res;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;  mode_d = mode_q;
        a_d = a_q;  x_d = x_q;  y_d = y_q;  s_d = s_q;  p_d = p_q;
        ir_d = ir_q;  data_d = data_q;  pc_d = pc_q;  ea_d = ea_q;
        int_nmi_d   = int_nmi_q;
        w_end       = 1'b0;
        w_nmi_clear = 1'b0;

        case (state_q)
            c_ST_RESET, c_ST_INT: state_d = c_ST_T1;
            c_ST_T0: begin
                ir_d    = dataBusInput;
                pc_d    = pc_q + 16'd1;
                state_d = c_ST_T1;
            end
            c_ST_T1: begin
                if (mode_q != c_MODE_INST) state_d = c_ST_T2;
                else case (w_cls)
                    OPC_BRANCH: begin
                        data_d = dataBusInput;
                        pc_d   = pc_q + 16'd1;
                        if (branch_taken(ir_q, p_q)) state_d = c_ST_T2;
                        else                         w_end   = 1'b1;
                    end
                    OPC_FLAG: begin
                        case (ir_q)
                            c_OP_CLC: p_d[c_P_C] = 1'b0;
                            c_OP_SEC: p_d[c_P_C] = 1'b1;
                            c_OP_CLI: p_d[c_P_I] = 1'b0;
                            c_OP_SEI: p_d[c_P_I] = 1'b1;
                            c_OP_CLV: p_d[c_P_V] = 1'b0;
                            c_OP_CLD: p_d[c_P_D] = 1'b0;
                            c_OP_SED: p_d[c_P_D] = 1'b1;
                            default:  ;
                        endcase
                        w_end = 1'b1;
                    end
                    OPC_REG: begin
                        if (ir_q == c_OP_INX || ir_q == c_OP_DEX) x_d = w_id_res;
                        else                                      y_d = w_id_res;
                        p_d[c_P_N] = w_id_n;
                        p_d[c_P_Z] = w_id_z;
                        w_end      = 1'b1;
                    end
                    OPC_INCDEC, OPC_JMP_ABS, OPC_JMP_IND: begin
                        ea_d[7:0] = dataBusInput;
                        pc_d      = pc_q + 16'd1;
                        state_d   = c_ST_T2;
                    end
                    default: w_end = 1'b1;
                endcase
            end
            c_ST_T2: begin
                if (mode_q != c_MODE_INST) begin
                    s_d     = s_q - 8'd1;
                    state_d = c_ST_T3;
                end else if (w_cls == OPC_BRANCH) begin
                    if (w_branch_target[15:8] == pc_q[15:8]) begin
                        pc_d  = w_branch_target;
                        w_end = 1'b1;
                    end else begin
                        // uncorrected address drives the extra dummy read
                        pc_d    = {pc_q[15:8], w_branch_target[7:0]};
                        ea_d    = w_branch_target;
                        state_d = c_ST_T3;
                    end
                end else if (w_cls == OPC_JMP_ABS) begin
                    pc_d  = {dataBusInput, ea_q[7:0]};
                    w_end = 1'b1;
                end else begin
                    ea_d[15:8] = dataBusInput;
                    pc_d       = pc_q + 16'd1;
                    state_d    = c_ST_T3;
                end
            end
            c_ST_T3: begin
                if (mode_q != c_MODE_INST) begin
                    s_d     = s_q - 8'd1;
                    state_d = c_ST_T4;
                end else if (w_cls == OPC_BRANCH) begin
                    pc_d  = ea_q;
                    w_end = 1'b1;
                end else begin
                    data_d  = dataBusInput;
                    state_d = c_ST_T4;
                end
            end
            c_ST_T4: begin
                if (mode_q != c_MODE_INST) begin
                    s_d     = s_q - 8'd1;
                    state_d = c_ST_T5;
                    if (mode_q == c_MODE_INT) p_d[c_P_I] = 1'b1;
                end else if (w_cls == OPC_JMP_IND) begin
                    pc_d  = {dataBusInput, data_q};
                    w_end = 1'b1;
                end else begin
                    state_d = c_ST_T5;
                end
            end
            c_ST_T5: begin
                if (mode_q != c_MODE_INST) begin
                    pc_d[7:0] = dataBusInput;
                    state_d   = c_ST_T6;
                end else begin
                    data_d     = w_id_res;
                    p_d[c_P_N] = w_id_n;
                    p_d[c_P_Z] = w_id_z;
                    w_end      = 1'b1;
                end
            end
            c_ST_T6: begin
                pc_d[15:8] = dataBusInput;
                w_end      = 1'b1;
            end
            default: state_d = c_ST_RESET;
        endcase

        if (w_end) begin
            if (w_take_int) begin
                state_d     = c_ST_INT;
                mode_d      = c_MODE_INT;
                int_nmi_d   = nmi_pend_q;
                w_nmi_clear = nmi_pend_q;
            end else begin
                state_d = c_ST_T0;
                mode_d  = c_MODE_INST;
            end
        end

        if (so_prev_q & ~setOverflow) p_d[c_P_V] = 1'b1;
        so_prev_d  = setOverflow;
        nmi_prev_d = nonMaskableInterrupt;
        nmi_pend_d = (nmi_pend_q & ~w_nmi_clear) | (nonMaskableInterrupt & ~nmi_prev_q);
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q    <= c_ST_RESET;
            mode_q     <= c_MODE_RST;
            a_q        <= 8'h00;
            x_q        <= 8'h00;
            y_q        <= 8'h00;
            s_q        <= 8'h00;
            p_q        <= c_P_RESET;
            ir_q       <= 8'h00;
            data_q     <= 8'h00;
            pc_q       <= 16'h0000;
            ea_q       <= 16'h0000;
            int_nmi_q  <= 1'b0;
            nmi_prev_q <= 1'b0;
            nmi_pend_q <= 1'b0;
            so_prev_q  <= 1'b0;
        end else if (!w_stall) begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            a_q        <= a_d;
            x_q        <= x_d;
            y_q        <= y_d;
            s_q        <= s_d;
            p_q        <= p_d;
            ir_q       <= ir_d;
            data_q     <= data_d;
            pc_q       <= pc_d;
            ea_q       <= ea_d;
            int_nmi_q  <= int_nmi_d;
            nmi_prev_q <= nmi_prev_d;
            nmi_pend_q <= nmi_pend_d;
            so_prev_q  <= so_prev_d;
        end
    end

    assign addressBusHigh = w_addr[15:8];
    assign addressBusLow  = w_addr[7:0];
    assign dataBusOutput  = w_dout;
    assign readNotWrite   = nrst | w_rnw;
    assign dataBusEnable  = ~nrst & ~w_rnw;
    assign sync           = ~nrst & w_sync;

endmodule
`default_nettype wire

// File: tb/tb_top_8227.sv
`default_nettype none
// ============================================================================
// tb_top_8227 : directed program run against a flat 64 KiB memory model
// Rev 1.0
// ============================================================================
module tb_top_8227;

    logic        clk = 1'b0;
    logic        nrst, nmi, irq, rdy, so;
    logic [7:0]  din, dout, ahi, alo;
    logic        dbe, sync, rnw;
    logic [15:0] addr;
    logic [15:0] ncyc;
    logic [7:0]  mem [0:65535];
    int          n_vec = 0;
    int          n_miscmp = 0;

    top_8227 dut (
        .clk                  (clk),
        .nrst                 (nrst),
        .nonMaskableInterrupt (nmi),
        .interruptRequest     (irq),
        .dataBusInput         (din),
        .dataBusOutput        (dout),
        .addressBusHigh       (ahi),
        .addressBusLow        (alo),
        .dataBusEnable        (dbe),
        .ready                (rdy),
        .sync                 (sync),
        .readNotWrite         (rnw),
        .setOverflow          (so)
    );

    always #5 clk = ~clk;

    assign addr = {ahi, alo};
    assign din  = mem[addr];

    function automatic logic [15:0] ext8(input logic [7:0] v);
        ext8 = {8'h00, v};
    endfunction

    function automatic logic [15:0] ext1(input logic v);
        ext1 = {15'h0000, v};
    endfunction

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Mid-cycle write capture, then advance to just after the next rising edge
    task automatic step();
        @(negedge clk);
        if (!rnw) mem[addr] = dout;
        @(posedge clk);
        #1;
    endtask

    task automatic next_fetch(output logic [15:0] n);
        n = 16'd0;
        do begin
            step();
            n = n + 16'd1;
        end while (!sync && n < 16'd40);
        if (!sync) check_val("fetch_timeout", ext1(sync), 16'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        nrst = 1'b1; nmi = 1'b0; irq = 1'b0; rdy = 1'b1; so = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'hFFFC] = 8'hDD; mem[16'hFFFD] = 8'hCC;
        mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h05;
        mem[16'hCCDD] = 8'h4C; mem[16'hCCDE] = 8'h00; mem[16'hCCDF] = 8'h02;
        mem[16'h0200] = 8'h18; mem[16'h0201] = 8'h90; mem[16'h0202] = 8'h10;
        mem[16'h0213] = 8'h38; mem[16'h0214] = 8'h90; mem[16'h0215] = 8'h55;
        mem[16'h0216] = 8'h4C; mem[16'h0217] = 8'hF0; mem[16'h0218] = 8'h02;
        mem[16'h02F0] = 8'hB0; mem[16'h02F1] = 8'h20;
        mem[16'h0312] = 8'hCE; mem[16'h0313] = 8'h00; mem[16'h0314] = 8'h01;
        mem[16'h0315] = 8'hEE; mem[16'h0316] = 8'h00; mem[16'h0317] = 8'h01;
        mem[16'h0318] = 8'h6C; mem[16'h0319] = 8'hFF; mem[16'h031A] = 8'h03;
        mem[16'h03FF] = 8'h34; mem[16'h0300] = 8'hCD; mem[16'h0400] = 8'hEE;
        mem[16'h0100] = 8'h00;
        mem[16'hCD34] = 8'hCA; mem[16'hCD35] = 8'hE8;

        step(); step();
        check_val("rst_rnw",  ext1(rnw),       16'd1);
        check_val("rst_dbe",  ext1(dbe),       16'd0);
        check_val("rst_sync", ext1(sync),      16'd0);
        check_val("rst_s",    ext8(dut.s_q),   16'h0000);
        check_val("rst_p",    ext8(dut.p_q),   16'h0034);
        check_val("rst_x",    ext8(dut.x_q),   16'h0000);

        nrst = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 3) check_val("boot_c3_addr", addr, 16'h0100);
            if (c == 6) check_val("boot_c6_addr", addr, 16'hFFFC);
            if (c == 7) check_val("boot_c7_addr", addr, 16'hFFFD);
            step();
        end
        check_val("boot_fetch_addr", addr, 16'hCCDD);
        check_val("boot_fetch_sync", ext1(sync), 16'd1);
        check_val("boot_s", ext8(dut.s_q), 16'h00FD);

        nrst = 1'b1;
        step();
        nrst = 1'b0;
        step(); step();
        rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_val("stall_addr", addr, 16'h0100);
        end
        rdy = 1'b1;
        step(); step(); step();
        check_val("stall_c6_addr", addr, 16'hFFFC);
        step(); step();
        check_val("stall_fetch_addr", addr, 16'hCCDD);
        check_val("stall_fetch_sync", ext1(sync), 16'd1);

        next_fetch(ncyc); check_val("jmp_cyc", ncyc, 16'd3); check_val("jmp_pc", addr, 16'h0200);
        next_fetch(ncyc); check_val("clc_cyc", ncyc, 16'd2); check_val("clc_pc", addr, 16'h0201);
        next_fetch(ncyc); check_val("bcc_t_cyc", ncyc, 16'd3); check_val("bcc_t_pc", addr, 16'h0213);
        next_fetch(ncyc); check_val("sec_cyc", ncyc, 16'd2); check_val("sec_pc", addr, 16'h0214);
        next_fetch(ncyc); check_val("bcc_n_cyc", ncyc, 16'd2); check_val("bcc_n_pc", addr, 16'h0216);
        next_fetch(ncyc); check_val("jmp2_cyc", ncyc, 16'd3); check_val("jmp2_pc", addr, 16'h02F0);

        step(); step(); step();
        check_val("bcs_dummy_addr", addr, 16'h0212);
        check_val("bcs_dummy_sync", ext1(sync), 16'd0);
        step();
        check_val("bcs_fetch_addr", addr, 16'h0312);
        check_val("bcs_fetch_sync", ext1(sync), 16'd1);

        step(); step(); step(); step();
        check_val("dec_w1_rnw",  ext1(rnw),  16'd0);
        check_val("dec_w1_dbe",  ext1(dbe),  16'd1);
        check_val("dec_w1_addr", addr,       16'h0100);
        check_val("dec_w1_data", ext8(dout), 16'h0000);
        step();
        check_val("dec_w2_rnw",  ext1(rnw),  16'd0);
        check_val("dec_w2_data", ext8(dout), 16'h00FF);
        step();
        check_val("dec_next_pc", addr, 16'h0315);
        check_val("dec_n", ext1(dut.p_q[7]), 16'd1);
        check_val("dec_z", ext1(dut.p_q[1]), 16'd0);
        check_val("dec_mem", ext8(mem[16'h0100]), 16'h00FF);

        step(); step(); step(); step();
        check_val("inc_w1_data", ext8(dout), 16'h00FF);
        step();
        check_val("inc_w2_data", ext8(dout), 16'h0000);
        step();
        check_val("inc_next_pc", addr, 16'h0318);
        check_val("inc_z", ext1(dut.p_q[1]), 16'd1);
        check_val("inc_n", ext1(dut.p_q[7]), 16'd0);
        check_val("inc_mem", ext8(mem[16'h0100]), 16'h0000);

        next_fetch(ncyc); check_val("jmpi_cyc", ncyc, 16'd5); check_val("jmpi_pc", addr, 16'hCD34);
        next_fetch(ncyc); check_val("dex_cyc", ncyc, 16'd2);
        check_val("dex_x", ext8(dut.x_q), 16'h00FF);
        check_val("dex_n", ext1(dut.p_q[7]), 16'd1);
        next_fetch(ncyc); check_val("inx_pc", addr, 16'hCD36);
        check_val("inx_x", ext8(dut.x_q), 16'h0000);
        check_val("inx_z", ext1(dut.p_q[1]), 16'd1);

        nmi = 1'b1;
        next_fetch(ncyc);
        check_val("nmi_cyc", ncyc, 16'd9);
        check_val("nmi_pc", addr, 16'h0500);
        check_val("nmi_push_pch", ext8(mem[16'h01FD]), 16'h00CD);
        check_val("nmi_push_pcl", ext8(mem[16'h01FC]), 16'h0037);
        check_val("nmi_push_p",   ext8(mem[16'h01FB]), 16'h0027);
        check_val("nmi_s", ext8(dut.s_q), 16'h00FA);
        check_val("nmi_i", ext1(dut.p_q[2]), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
`default_nettype wire
